tug_round_controller: RTL and testbench

Referee and sequencer for the tug-of-war light bar.
- Turns raw player key levels into single-cycle press pulses for the light cells.
- Detects a round win when an end light is lit and that side presses again.
- Keeps per-player scores and drives the round-restart strobe that recentres the bar.
- Ends the game when either score saturates.

---
 rtl/tug_round_if.sv | 35 +++
 rtl/tug_round_controller.sv | 133 +++++++++++++
 tb/tb_tug_round_controller.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/tug_round_if.sv
// tug_round_if
//   Bundles the referee's key inputs, light-bar input and its game outputs.
//   master : the round controller (reads keys/lights, drives presses, scores, status)
//   slave  : the surrounding game (drives keys/lights, reads controller outputs)
//   Signals:
//     L_raw, R_raw        key levels, 1 = pressed
//     lights[NUM_LIGHTS]  light-bar state, bit 0 rightmost
//     L_press, R_press    one-cycle press pulses to the cells
//     round_rst           recentre strobe for the bar
//     left_score, right_score, winner, game_over   game status
interface tug_round_if #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3
);
  logic                  L_raw;
  logic                  R_raw;
  logic [NUM_LIGHTS-1:0] lights;
  logic                  L_press;
  logic                  R_press;
  logic                  round_rst;
  logic [SCORE_W-1:0]    left_score;
  logic [SCORE_W-1:0]    right_score;
  logic [1:0]            winner;
  logic                  game_over;

  modport master (
    input  L_raw, R_raw, lights,
    output L_press, R_press, round_rst, left_score, right_score, winner, game_over
  );

  modport slave (
    output L_raw, R_raw, lights,
    input  L_press, R_press, round_rst, left_score, right_score, winner, game_over
  );
endinterface

// File: rtl/tug_round_controller.sv
// tug_round_controller
//   Referee/sequencer for the tug-of-war light bar: turns key levels into
//   single press pulses, detects round wins at the bar ends, keeps scores,
//   strobes round_rst to recentre the bar and stops the game at max score.
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous active-high reset
//     bus    tug_round_if.master (keys, lights in; presses, strobe, scores out)
module tug_round_controller #(
  parameter int NUM_LIGHTS  = 9,
  parameter int SCORE_W     = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  tug_round_if.master  bus
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    RESTART  = 2'd0,
    PLAY     = 2'd1,
    WIN_HOLD = 2'd2,
    OVER     = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic [SCORE_W-1:0] r_left_score;
  logic [SCORE_W-1:0] r_right_score;
  logic [1:0]         r_winner;
  logic               r_game_over;
  logic               r_prev_l;
  logic               r_prev_r;

  logic w_play;
  logic w_l_press;
  logic w_r_press;
  logic w_left_win;
  logic w_right_win;
  logic w_winner_maxed;
  logic w_unused_lights;

  // Only the two end cells matter to the referee.
  assign w_unused_lights = ^bus.lights;

  assign w_play = (r_state == PLAY);

  // Presses are combinational so the cells see the pulse in the same cycle
  // the key level rises. The history registers track keys in every state,
  // so a key held across a restart does not fire on entry to PLAY.
  assign w_l_press = bus.L_raw & ~r_prev_l & w_play & ~reset;
  assign w_r_press = bus.R_raw & ~r_prev_r & w_play & ~reset;

  // A simultaneous press is no move for the cells, so it can never win.
  assign w_left_win  = bus.lights[NUM_LIGHTS-1] & w_l_press & ~w_r_press;
  assign w_right_win = bus.lights[0]            & w_r_press & ~w_l_press;

  assign w_winner_maxed = ((r_winner == 2'b10) && (r_left_score  == SCORE_MAX)) ||
                          ((r_winner == 2'b01) && (r_right_score == SCORE_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RESTART;
      r_hold_cnt    <= '0;
      r_left_score  <= '0;
      r_right_score <= '0;
      r_winner      <= 2'b00;
      r_game_over   <= 1'b0;
      r_prev_l      <= 1'b0;
      r_prev_r      <= 1'b0;
    end else begin
      r_prev_l <= bus.L_raw;
      r_prev_r <= bus.R_raw;
      case (r_state)
        RESTART: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state    <= PLAY;
            r_hold_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        PLAY: begin
          if (w_left_win) begin
            r_left_score <= r_left_score + 1'b1;
            r_winner     <= 2'b10;
            r_state      <= WIN_HOLD;
            r_hold_cnt   <= '0;
          end else if (w_right_win) begin
            r_right_score <= r_right_score + 1'b1;
            r_winner      <= 2'b01;
            r_state       <= WIN_HOLD;
            r_hold_cnt    <= '0;
          end
        end
        WIN_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_hold_cnt <= '0;
            // The score already incremented on entry, so compare to max here.
            if (w_winner_maxed) begin
              r_state     <= OVER;
              r_game_over <= 1'b1;
            end else begin
              r_state  <= RESTART;
              r_winner <= 2'b00;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        OVER: begin
          // Terminal until reset.
        end
        default: begin
          r_state <= RESTART;
        end
      endcase
    end
  end

  assign bus.L_press     = w_l_press;
  assign bus.R_press     = w_r_press;
  assign bus.round_rst   = reset | (r_state == RESTART);
  assign bus.left_score  = r_left_score;
  assign bus.right_score = r_right_score;
  assign bus.winner      = r_winner;
  assign bus.game_over   = r_game_over;

endmodule

// File: tb/tb_tug_round_controller.sv
// Directed bench for tug_round_controller with default parameters
// (9 lights, 3-bit scores, 4-cycle hold). Inputs change 1 ns after a rising
// edge; outputs are checked 1 ns after that, well away from the next edge.
module tb_tug_round_controller;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  tug_round_if #(.NUM_LIGHTS(9), .SCORE_W(3)) bus ();

  tug_round_controller #(
    .NUM_LIGHTS (9),
    .SCORE_W    (3),
    .HOLD_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From PLAY with keys released: one side presses at its lit end cell.
  // Returns 1 ns into the first WIN_HOLD cycle with keys released again.
  task automatic do_win(input bit left, input int exp_l, input int exp_r);
    if (left) begin
      bus.lights = 9'b100000000;
      bus.L_raw  = 1'b1;
    end else begin
      bus.lights = 9'b000000001;
      bus.R_raw  = 1'b1;
    end
    #1;
    chk(left ? "win_l_press" : "win_r_press",
        left ? int'(bus.L_press) : int'(bus.R_press), 1);
    tick();
    bus.L_raw  = 1'b0;
    bus.R_raw  = 1'b0;
    bus.lights = '0;
    chk("win_l_score", int'(bus.left_score), exp_l);
    chk("win_r_score", int'(bus.right_score), exp_r);
    chk("win_winner", int'(bus.winner), left ? 2 : 1);
  endtask

  // From the first WIN_HOLD cycle, run hold (4) and restart (4) back to PLAY.
  task automatic finish_round();
    for (int i = 0; i < 8; i++) tick();
    chk("round_play", int'(bus.round_rst), 0);
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    reset      = 1'b1;
    bus.L_raw  = 1'b0;
    bus.R_raw  = 1'b0;
    bus.lights = '0;

    // 1: reset two cycles, then 4 restart cycles, then PLAY
    #1;
    chk("rst_round_rst", int'(bus.round_rst), 1);
    chk("rst_l_press", int'(bus.L_press), 0);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_winner", int'(bus.winner), 0);
    chk("rst_game_over", int'(bus.game_over), 0);
    for (int i = 0; i < 4; i++) begin
      chk("restart_round_rst", int'(bus.round_rst), 1);
      tick();
    end
    chk("play_round_rst", int'(bus.round_rst), 0);
    chk("play_l_score", int'(bus.left_score), 0);
    chk("play_r_score", int'(bus.right_score), 0);
    chk("play_winner", int'(bus.winner), 0);
    chk("idle_l_press", int'(bus.L_press), 0);
    chk("idle_r_press", int'(bus.R_press), 0);

    // 2: hold L for 5 cycles -> one pulse in the rising cycle only
    bus.L_raw = 1'b1;
    #1;
    chk("hold_pulse", int'(bus.L_press), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_no_pulse", int'(bus.L_press), 0);
    end
    tick();
    bus.L_raw = 1'b0;
    tick();

    // 3: left wins at the left end, L stays held through hold and restart
    bus.lights = 9'b100000000;
    bus.L_raw  = 1'b1;
    #1;
    chk("lwin_press", int'(bus.L_press), 1);
    tick();
    bus.lights = '0;
    chk("lwin_score", int'(bus.left_score), 1);
    chk("lwin_r_score", int'(bus.right_score), 0);
    for (int i = 0; i < 4; i++) begin
      chk("lhold_winner", int'(bus.winner), 2);
      chk("lhold_round_rst", int'(bus.round_rst), 0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      chk("lrst_winner", int'(bus.winner), 0);
      chk("lrst_round_rst", int'(bus.round_rst), 1);
      tick();
    end
    chk("held_into_play", int'(bus.L_press), 0);
    chk("held_round_rst", int'(bus.round_rst), 0);
    tick();
    chk("held_still_none", int'(bus.L_press), 0);
    bus.L_raw = 1'b0;
    tick();
    bus.L_raw = 1'b1;
    #1;
    chk("repress_pulse", int'(bus.L_press), 1);
    tick();
    bus.L_raw = 1'b0;
    tick();

    // 4: both keys rise together with the right end lit -> no win
    bus.lights = 9'b000000001;
    bus.L_raw  = 1'b1;
    bus.R_raw  = 1'b1;
    tick();
    chk("both_winner", int'(bus.winner), 0);
    chk("both_l_score", int'(bus.left_score), 1);
    chk("both_r_score", int'(bus.right_score), 0);
    chk("both_round_rst", int'(bus.round_rst), 0);
    bus.L_raw  = 1'b0;
    bus.R_raw  = 1'b0;
    bus.lights = '0;
    tick();

    // 5: right wins 7 rounds -> game over, further presses ignored
    for (int k = 1; k <= 7; k++) begin
      do_win(1'b0, 1, k);
      if (k < 7) finish_round();
    end
    for (int i = 0; i < 4; i++) begin
      chk("final_hold_go", int'(bus.game_over), 0);
      tick();
    end
    chk("over_game_over", int'(bus.game_over), 1);
    chk("over_winner", int'(bus.winner), 1);
    chk("over_round_rst", int'(bus.round_rst), 0);
    bus.lights = 9'b000000001;
    bus.R_raw  = 1'b1;
    #1;
    chk("over_r_press", int'(bus.R_press), 0);
    tick();
    bus.R_raw = 1'b0;
    bus.lights = 9'b100000000;
    tick();
    bus.L_raw = 1'b1;
    #1;
    chk("over_l_press", int'(bus.L_press), 0);
    tick();
    bus.L_raw  = 1'b0;
    bus.lights = '0;
    chk("over_l_score", int'(bus.left_score), 1);
    chk("over_r_score", int'(bus.right_score), 7);
    chk("over_winner_held", int'(bus.winner), 1);

    // reset out of OVER
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("over_rst_go", int'(bus.game_over), 0);
    chk("over_rst_r_score", int'(bus.right_score), 0);
    chk("over_rst_round_rst", int'(bus.round_rst), 1);
    for (int i = 0; i < 4; i++) tick();
    chk("over_rst_play", int'(bus.round_rst), 0);

    // 6: reach 3/2, then reset in the middle of the win hold
    do_win(1'b1, 1, 0); finish_round();
    do_win(1'b1, 2, 0); finish_round();
    do_win(1'b1, 3, 0); finish_round();
    do_win(1'b0, 3, 1); finish_round();
    do_win(1'b0, 3, 2);
    tick();
    chk("mid_hold_round_rst", int'(bus.round_rst), 0);
    reset = 1'b1;
    tick();
    chk("mid_rst_l_score", int'(bus.left_score), 0);
    chk("mid_rst_r_score", int'(bus.right_score), 0);
    chk("mid_rst_winner", int'(bus.winner), 0);
    chk("mid_rst_round_rst", int'(bus.round_rst), 1);
    chk("mid_rst_game_over", int'(bus.game_over), 0);
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
